// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table,
// blank pattern and bit positions on the {a..g,dp} bus.
package seg7_pkg;

   // Segment bit positions on the 8-bit bus, a is the MSB.
   localparam int SEG_A  = 7;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   // a..g, active-high, indexed by hex value.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex-to-segment lookup (a..g, active-high).
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] hex_i,
   output logic [6:0] seg_o
);

   assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment scan driver with frame-synchronous double
// buffering, one dead cycle per digit slot and leading-zero blanking.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int NDIGITS  = 4,
   parameter int DIV      = 50000,
   parameter int BLANK_LZ = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [4*NDIGITS-1:0]   data,
   input  logic [NDIGITS-1:0]     dp_in,
   output logic [7:0]             seg_n,
   output logic [NDIGITS-1:0]     an_n,
   output logic                   frame_done
);

   localparam int CW = $clog2(DIV);
   localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   logic [CW-1:0]          cnt_q, cnt_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [4*NDIGITS-1:0]   pend_data_q, act_data_q;
   logic [NDIGITS-1:0]     pend_dp_q, act_dp_q;
   logic [7:0]             seg_q, seg_d;
   logic [NDIGITS-1:0]     an_q, an_d;
   logic                   fd_q;

   logic                   frame_end;
   logic [NDIGITS-1:0]     lz;
   logic [3:0]             digit;
   logic                   dp_cur, blank_cur;
   logic [6:0]             glyph;

   assign frame_end = (cnt_q == CW'(DIV-1)) && (idx_q == IW'(NDIGITS-1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      if (cnt_q == CW'(DIV-1)) begin
         cnt_d = '0;
         idx_d = (idx_q == IW'(NDIGITS-1)) ? '0 : idx_q + 1'b1;
      end
   end

   // Digit i is blanked when it and every more significant digit are zero.
   for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_d0
         assign lz[gi] = 1'b0;
      end else begin : g_dn
         assign lz[gi] = (BLANK_LZ != 0) && (act_data_q[4*NDIGITS-1:4*gi] == '0);
      end
   end

   always_comb begin
      digit     = '0;
      dp_cur    = 1'b0;
      blank_cur = 1'b0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            digit     = act_data_q[4*i +: 4];
            dp_cur    = act_dp_q[i];
            blank_cur = lz[i];
         end
      end
   end

   seg7_decode u_dec (
      .hex_i (digit),
      .seg_o (glyph)
   );

   // cnt==0 is the anti-ghosting dead slot: everything dark.
   always_comb begin
      seg_d = SEG_BLANK;
      an_d  = '1;
      if (cnt_q != '0) begin
         seg_d[SEG_A:SEG_G] = blank_cur ? 7'h7F : ~glyph;
         seg_d[SEG_DP]      = ~dp_cur;
         for (int i = 0; i < NDIGITS; i++) begin
            if (idx_q == IW'(i)) an_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         idx_q       <= '0;
         pend_data_q <= '0;
         pend_dp_q   <= '0;
         act_data_q  <= '0;
         act_dp_q    <= '0;
         seg_q       <= SEG_BLANK;
         an_q        <= '1;
         fd_q        <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         if (load) begin
            pend_data_q <= data;
            pend_dp_q   <= dp_in;
         end
         // A load landing on the frame-end edge bypasses the pending buffer.
         if (frame_end) begin
            act_data_q <= load ? data  : pend_data_q;
            act_dp_q   <= load ? dp_in : pend_dp_q;
         end
         seg_q <= seg_d;
         an_q  <= an_d;
         fd_q  <= frame_end;
      end
   end

   assign seg_n      = seg_q;
   assign an_n       = an_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan (NDIGITS=4, DIV=4): scan timing, blanking,
// double-buffer commit, coincident load and mid-frame reset.
module tb_seg7_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic        load;
   logic [15:0] data;
   logic [3:0]  dp_in;
   logic [7:0]  seg_n, seg_n0;
   logic [3:0]  an_n, an_n0;
   logic        frame_done, frame_done0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   seg7_scan #(.NDIGITS(4), .DIV(4), .BLANK_LZ(1)) dut (
      .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in),
      .seg_n(seg_n), .an_n(an_n), .frame_done(frame_done)
   );

   seg7_scan #(.NDIGITS(4), .DIV(4), .BLANK_LZ(0)) dut0 (
      .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in),
      .seg_n(seg_n0), .an_n(an_n0), .frame_done(frame_done0)
   );

   // Expected seg_n per frame (rows) and digit (columns), lit slots only.
   logic [7:0] exp_tab [6][4] = '{
      '{8'h03, 8'hFF, 8'hFF, 8'hFF},   // all zero, blanked
      '{8'h49, 8'h11, 8'hFF, 8'hFF},   // 00A5
      '{8'h49, 8'h11, 8'hFF, 8'hFF},   // 1234 pending, not yet shown
      '{8'h99, 8'h0D, 8'h25, 8'h9F},   // 1234
      '{8'h9F, 8'hFF, 8'hFF, 8'hFE},   // 0001 with dp on digit 3
      '{8'h9F, 8'hFF, 8'hFF, 8'hFE}
   };
   logic [7:0] exp_tab0 [2][4] = '{
      '{8'h03, 8'h03, 8'h03, 8'h03},
      '{8'h49, 8'h11, 8'h03, 8'h03}
   };

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] exp_an;
      logic [7:0] exp_seg;
      bit         dead;
      int         d, f;

      rst = 1'b1; load = 1'b0; data = '0; dp_in = '0;
      tick(); tick();
      chk("reset seg_n", seg_n, 8'hFF);
      chk("reset an_n", {4'h0, an_n}, 8'h0F);
      chk("reset frame_done", {7'h0, frame_done}, 8'h00);

      // Release reset with a load already presented for edge 1.
      rst = 1'b0; load = 1'b1; data = 16'h00A5; dp_in = 4'b0000;

      for (int k = 1; k <= 86; k++) begin
         tick();
         dead   = ((k - 1) % 4) == 0;
         d      = ((k - 1) / 4) % 4;
         f      = (k - 1) / 16;
         exp_an = 4'hF;
         if (!dead) exp_an[d] = 1'b0;
         exp_seg = dead ? 8'hFF : exp_tab[f][d];
         chk($sformatf("an_n k=%0d", k), {4'h0, an_n}, {4'h0, exp_an});
         chk($sformatf("seg_n k=%0d", k), seg_n, exp_seg);
         chk($sformatf("frame_done k=%0d", k), {7'h0, frame_done}, {7'h0, (k % 16) == 0});
         if (f < 2) begin
            chk($sformatf("nolz seg_n k=%0d", k), seg_n0, dead ? 8'hFF : exp_tab0[f][d]);
         end
         // Stimulus for the next edge.
         load = 1'b0;
         case (k)
            33: begin load = 1'b1; data = 16'h5555; end
            34: begin load = 1'b1; data = 16'h1234; end  // last one wins
            63: begin load = 1'b1; data = 16'h0001; dp_in = 4'b1000; end  // frame-end edge 64
            83: begin load = 1'b1; data = 16'hBEEF; dp_in = 4'b0000; end
            default: ;
         endcase
      end

      // Mid-frame reset; the next slot would otherwise be lit.
      rst = 1'b1;
      tick();
      chk("midrst seg_n", seg_n, 8'hFF);
      chk("midrst an_n", {4'h0, an_n}, 8'h0F);
      chk("midrst frame_done", {7'h0, frame_done}, 8'h00);
      rst = 1'b0;

      for (int j = 1; j <= 18; j++) begin
         tick();
         if (j == 1) chk("post-rst dead an_n", {4'h0, an_n}, 8'h0F);
         if (j == 2) begin
            chk("post-rst digit0 an_n", {4'h0, an_n}, 8'h0E);
            chk("post-rst digit0 seg_n", seg_n, 8'h03);
         end
         if (j == 16) chk("post-rst frame_done", {7'h0, frame_done}, 8'h01);
         if (j == 18) begin
            chk("pending discarded an_n", {4'h0, an_n}, 8'h0E);
            chk("pending discarded seg_n", seg_n, 8'h03);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
